// File: rtl/swap_array_pkg.sv
// Shared opcode constants, FSM state type and opcode helper for swap_array.
package swap_array_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SWAP = 3'd2;
  localparam logic [2:0] OP_ROTL = 3'd3;
  localparam logic [2:0] OP_ROTR = 3'd4;
  localparam logic [2:0] OP_SORT = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SORT = 1'b1
  } state_e;

  // Codes above SORT are reserved and treated as NOP with an error flag.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_SORT);
  endfunction

endpackage

// File: rtl/swap_array_cmp_swap.sv
// One unsigned compare-exchange: lo/hi are the ordered pair; equal inputs pass straight through.
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  assign swap = (x > y);
  assign lo   = swap ? y : x;
  assign hi   = swap ? x : y;

endmodule

// File: rtl/swap_array.sv
// Register array with LOAD/SWAP/rotate single-cycle commands and a multi-cycle
// odd-even transposition SORT.
module swap_array
  import swap_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [$clog2(N)-1:0]   cmd_idx_a,
  input  logic [$clog2(N)-1:0]   cmd_idx_b,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic [N*WIDTH-1:0]     regs_flat,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int IW = $clog2(N);

  state_e            state;
  state_e            state_next;
  logic [IW-1:0]     phase;
  logic [WIDTH-1:0]  regs      [N];
  logic [WIDTH-1:0]  regs_next [N];
  logic [WIDTH-1:0]  rotl      [N];
  logic [WIDTH-1:0]  rotr      [N];
  logic [WIDTH-1:0]  even_res  [N];
  logic [WIDTH-1:0]  odd_res   [N];
  logic [WIDTH-1:0]  lo        [N-1];
  logic [WIDTH-1:0]  hi        [N-1];
  logic              done_next;
  logic              err_next;
  logic              last_phase;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state == ST_SORT);
  assign last_phase = (phase == IW'(N - 1));

  // One comparator per adjacent pair; the phase parity picks which pairs commit.
  for (genvar k = 0; k < N - 1; k++) begin : g_cmp
    cmp_swap #(.WIDTH(WIDTH)) u_cmp (
      .x  (regs[k]),
      .y  (regs[k+1]),
      .lo (lo[k]),
      .hi (hi[k])
    );
  end

  for (genvar k = 0; k < N; k++) begin : g_route
    assign rotl[k] = regs[(k + 1) % N];
    assign rotr[k] = regs[(k + N - 1) % N];
    assign regs_flat[k*WIDTH +: WIDTH] = regs[k];

    if (k % 2 == 0) begin : g_even_left
      assign even_res[k] = lo[k];
    end else begin : g_even_right
      assign even_res[k] = hi[k-1];
    end

    // In odd phases reg0 and reg[N-1] have no partner and hold their value.
    if ((k % 2 == 1) && (k < N - 1)) begin : g_odd_left
      assign odd_res[k] = lo[k];
    end else if ((k % 2 == 0) && (k > 0)) begin : g_odd_right
      assign odd_res[k] = hi[k-1];
    end else begin : g_odd_hold
      assign odd_res[k] = regs[k];
    end
  end

  always_comb begin
    regs_next  = regs;
    state_next = state;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          done_next = (cmd_op != OP_SORT);
          err_next  = op_illegal(cmd_op);
          case (cmd_op)
            OP_LOAD: regs_next[cmd_idx_a] = cmd_data;
            OP_SWAP: begin
              regs_next[cmd_idx_a] = regs[cmd_idx_b];
              regs_next[cmd_idx_b] = regs[cmd_idx_a];
            end
            OP_ROTL: regs_next = rotl;
            OP_ROTR: regs_next = rotr;
            OP_SORT: state_next = ST_SORT;
            default: ;
          endcase
        end
      end
      ST_SORT: begin
        regs_next = phase[0] ? odd_res : even_res;
        if (last_phase) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        regs[k] <= '0;
      end
    end else begin
      state <= state_next;
      phase <= (state == ST_SORT && !last_phase) ? phase + 1'b1 : '0;
      done  <= done_next;
      err   <= err_next;
      regs  <= regs_next;
    end
  end

endmodule

// File: tb/tb_swap_array.sv
// Directed plus randomized check of swap_array against an array/queue reference model.
module tb_swap_array;

  localparam int N = 4;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_op = '0;
  logic [1:0]      cmd_idx_a = '0;
  logic [1:0]      cmd_idx_b = '0;
  logic [W-1:0]    cmd_data = '0;
  logic [N*W-1:0]  regs_flat;
  logic            busy;
  logic            done;
  logic            err;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] m [N];

  swap_array #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx_a (cmd_idx_a),
    .cmd_idx_b (cmd_idx_b),
    .cmd_data  (cmd_data),
    .regs_flat (regs_flat),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mflat();
    logic [31:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = m[k];
    return f;
  endfunction

  task automatic model_apply(input logic [2:0] op, input int a, input int b, input logic [W-1:0] d);
    logic [W-1:0] t;
    logic [W-1:0] q [$];
    case (op)
      3'd1: m[a] = d;
      3'd2: begin t = m[a]; m[a] = m[b]; m[b] = t; end
      3'd3: begin t = m[0]; for (int k = 0; k < N - 1; k++) m[k] = m[k+1]; m[N-1] = t; end
      3'd4: begin t = m[N-1]; for (int k = N - 1; k > 0; k--) m[k] = m[k-1]; m[0] = t; end
      3'd5: begin
        q = {};
        for (int k = 0; k < N; k++) q.push_back(m[k]);
        q.sort();
        for (int k = 0; k < N; k++) m[k] = q[k];
      end
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [2:0] op, input int a, input int b, input logic [W-1:0] d);
    int c;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx_a = 2'(a); cmd_idx_b = 2'(b); cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (op == 3'd5) begin
      chk("sort_busy", {31'd0, busy}, 32'd1);
      chk("sort_hold", regs_flat, mflat());
      model_apply(op, a, b, d);
      c = 0;
      while (!done && c < N + 3) begin
        @(posedge clk); #1;
        c++;
      end
      chk("sort_latency", c, N);
      chk("sort_result", regs_flat, mflat());
      chk("sort_ready", {31'd0, cmd_ready}, 32'd1);
    end else begin
      model_apply(op, a, b, d);
      chk("cmd_done", {31'd0, done}, 32'd1);
      chk("cmd_err", {31'd0, err}, {31'd0, op >= 3'd6});
      chk("cmd_regs", regs_flat, mflat());
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) m[k] = '0;

    // Reset state
    #3;
    chk("rst_regs", regs_flat, 32'd0);
    chk("rst_flags", {28'd0, busy, done, err, cmd_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Back-to-back loads
    do_cmd(3'd1, 0, 0, 8'd10);
    do_cmd(3'd1, 1, 0, 8'd20);
    do_cmd(3'd1, 2, 0, 8'd30);
    do_cmd(3'd1, 3, 0, 8'd40);
    chk("load_flat", regs_flat, 32'h281E140A);
    @(posedge clk); #1;
    chk("done_clears", {30'd0, done, err}, 32'd0);

    // Swaps
    do_cmd(3'd2, 0, 1, 8'd0);
    chk("swap_flat", regs_flat, 32'h281E0A14);
    do_cmd(3'd2, 2, 2, 8'd0);
    chk("swap_same", regs_flat, 32'h281E0A14);

    // Rotations
    do_cmd(3'd1, 0, 0, 8'd1);
    do_cmd(3'd1, 1, 0, 8'd2);
    do_cmd(3'd1, 2, 0, 8'd3);
    do_cmd(3'd1, 3, 0, 8'd4);
    do_cmd(3'd3, 0, 0, 8'd0);
    chk("rotl_flat", regs_flat, 32'h01040302);
    do_cmd(3'd4, 0, 0, 8'd0);
    chk("rotr_flat", regs_flat, 32'h04030201);

    // Sort with a command held pending during the sort
    do_cmd(3'd1, 0, 0, 8'd40);
    do_cmd(3'd1, 1, 0, 8'd10);
    do_cmd(3'd1, 2, 0, 8'd40);
    do_cmd(3'd1, 3, 0, 8'd5);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5;
    @(posedge clk); #1;
    cmd_op = 3'd1; cmd_idx_a = 2'd0; cmd_data = 8'hEE;
    chk("ds_accept", {29'd0, busy, cmd_ready, done}, 32'b100);
    chk("ds_nochange", regs_flat, 32'h05280A28);
    for (int i = 1; i < N; i++) begin
      @(posedge clk); #1;
      chk("ds_busy", {29'd0, busy, cmd_ready, done}, 32'b100);
    end
    @(posedge clk); #1;
    chk("ds_done", {29'd0, busy, cmd_ready, done}, 32'b011);
    chk("ds_result", regs_flat, 32'h28280A05);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("ds_held_load", regs_flat, 32'h28280AEE);
    chk("ds_held_done", {31'd0, done}, 32'd1);
    for (int k = 0; k < N; k++) m[k] = regs_flat[k*W +: W] === 8'hEE ? 8'hEE : m[k];
    m[0] = 8'hEE; m[1] = 8'd10; m[2] = 8'd40; m[3] = 8'd40;

    // Illegal opcode
    do_cmd(3'd7, 1, 2, 8'h55);
    chk("ill_regs", regs_flat, 32'h28280AEE);

    // Reset in the middle of a sort
    do_cmd(3'd1, 0, 0, 8'd9);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_regs", regs_flat, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, done, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_nodone", {30'd0, done, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < N; k++) m[k] = '0;
    @(posedge clk); #1;
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Randomized commands
    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (i < 8) op = 3'd1;
      do_cmd(op, int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
             W'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/swap_array.md
SWAP_ARRAY -- requirements
Module: swap_array

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bit width of each register.
REQ-002 The block SHALL have parameter N, default 4, meaning number of registers; legal values are powers of two from 2 to 16.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port cmd_valid  input  1  command present.
REQ-006 Port cmd_ready  output  1  block can accept a command.
REQ-007 Port cmd_op  input  3  operation code.
REQ-008 Port cmd_idx_a  input  $clog2(N)  first register index.
REQ-009 Port cmd_idx_b  input  $clog2(N)  second register index.
REQ-010 Port cmd_data  input  WIDTH  LOAD data.
REQ-011 Port regs_flat  output  N*WIDTH  register contents; reg[k] at bits [k*WIDTH +: WIDTH].
REQ-012 Port busy  output  1  high while a SORT is in progress.
REQ-013 Port done  output  1  one-cycle pulse on command completion.
REQ-014 Port err  output  1  one-cycle pulse when an illegal opcode is accepted.

Function
REQ-015 The block SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-016 cmd_ready SHALL equal 1 in state IDLE and 0 in state SORT.
REQ-017 Opcodes SHALL be:
- 0 NOP
- 1 LOAD: reg[a] <= cmd_data
- 2 SWAP: reg[a] <-> reg[b]
- 3 ROTL: reg[k] <= reg[(k+1) mod N]
- 4 ROTR: reg[k] <= reg[(k-1) mod N]
- 5 SORT: ascending, unsigned
- 6 and 7: illegal
REQ-018 SWAP SHALL exchange both registers atomically on the accepting edge, with no transient state visible on regs_flat.
REQ-019 SWAP with a == b SHALL leave all registers unchanged and still pulse done.
REQ-020 NOP, LOAD, SWAP, ROTL and ROTR SHALL update registers on the accepting edge.
REQ-021 For NOP, LOAD, SWAP, ROTL and ROTR, done SHALL be 1 for exactly the following cycle.
REQ-022 An illegal opcode SHALL behave as NOP and additionally pulse err together with done.
REQ-023 The FSM SHALL have two states, IDLE and SORT.
REQ-024 Accepting SORT SHALL move the FSM IDLE->SORT with phase counter 0 and make no register change on the accepting edge.
REQ-025 In SORT, each cycle SHALL perform one odd-even transposition phase:
- even phase: compare-exchange pairs (0,1), (2,3), ...
- odd phase: compare-exchange pairs (1,2), (3,4), ...
- exchange only when left > right.
REQ-026 SORT SHALL run exactly N phases regardless of data, then return to IDLE.
REQ-027 done SHALL pulse in the cycle after the last phase, i.e. N+1 cycles after acceptance.
REQ-028 busy SHALL be 1 exactly while the FSM is in SORT.
REQ-029 Equal values SHALL never be exchanged.
REQ-030 cmd_* inputs SHALL be ignored while cmd_ready is 0.
REQ-031 Back-to-back single-cycle commands SHALL be accepted every cycle, each producing its own done pulse.

Reset
REQ-032 While rst_n is 0, the block SHALL immediately and asynchronously set:
- all registers to 0
- FSM to IDLE
- phase counter to 0
- done, err and busy to 0
REQ-033 Reset asserted mid-SORT SHALL abort the sort, with no done pulse.
REQ-034 cmd_ready SHALL be 1 from the first edge after rst_n deasserts.

Structure
REQ-035 Opcode constants and the FSM state type SHALL reside in package swap_array_pkg.
REQ-036 A combinational sub-module cmp_swap (inputs x, y; outputs lo, hi; parameter WIDTH) SHALL implement one compare-exchange.
REQ-037 cmp_swap SHALL be instantiated per adjacent pair, with the even/odd phase selecting which results are written back.

Verification (N=4, WIDTH=8)
REQ-038 Reset, then LOAD the four registers with 10, 20, 30, 40 -> regs_flat = {40,30,20,10} (reg3..reg0), four done pulses, no idle cycles between accepts.
REQ-039 From REQ-038's state, SWAP a=0 b=1 -> reg0=20, reg1=10 on the next cycle; then SWAP a=2 b=2 -> no change, done pulses.
REQ-040 From {reg0..reg3} = {1,2,3,4}:
- ROTL -> {2,3,4,1}
- then ROTR -> {1,2,3,4}
REQ-041 LOAD {reg0..reg3} = {40,10,40,5}, then SORT:
- result {5,10,40,40}
- busy high for 4 cycles, cmd_ready low for those cycles
- done 5 cycles after accept
- a cmd_valid held during the sort is not accepted until ready returns
REQ-042 Start SORT, assert rst_n=0 in phase 2 -> all registers 0 without a clock edge, no done pulse, ready=1 after release.
REQ-043 Issue opcode 7 -> err and done pulse together, registers unchanged.
